// File: rtl/slot_credit_allocator.sv
// Per-port free-slot credit allocator: grants each request to the enabled port with the most
// free slots (lowest index on ties), tracks releases/flushes, and counts accepted requests.

module max_finder_tree #(
  parameter int unsigned NUM_VALUES = 16,
  parameter int unsigned VAL_WIDTH  = 8,
  parameter int unsigned IDX_WIDTH  = 4
) (
  input  logic [NUM_VALUES*VAL_WIDTH-1:0] values_i,
  output logic [VAL_WIDTH-1:0]            max_val_o,
  output logic [IDX_WIDTH-1:0]            max_ptr_o
);

  localparam int unsigned Levels = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 0;
  localparam int unsigned Leaves = 1 << Levels;

  logic [VAL_WIDTH-1:0] node_val [Leaves];
  logic [IDX_WIDTH-1:0] node_idx [Leaves];

  // Pairwise reduction in place; the right operand wins only when strictly greater, so the
  // lower-indexed subtree keeps ties. Padding leaves are zero and sit at the highest indices.
  always_comb begin
    for (int i = 0; i < Leaves; i++) begin
      if (i < NUM_VALUES) begin
        node_val[i] = values_i[i*VAL_WIDTH +: VAL_WIDTH];
      end else begin
        node_val[i] = '0;
      end
      node_idx[i] = IDX_WIDTH'(i);
    end
    for (int s = 1; s < Leaves; s = s * 2) begin
      for (int i = 0; i < Leaves; i = i + 2 * s) begin
        if (node_val[i+s] > node_val[i]) begin
          node_val[i] = node_val[i+s];
          node_idx[i] = node_idx[i+s];
        end
      end
    end
    max_val_o = node_val[0];
    max_ptr_o = node_idx[0];
  end

endmodule

module slot_credit_allocator #(
  parameter int unsigned PORT_COUNT = 16,
  parameter int unsigned SLOT_WIDTH = 8,
  parameter int unsigned MAX_SLOTS  = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(PORT_COUNT)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PORT_COUNT-1:0]            port_enable,
  input  logic [PORT_COUNT-1:0]            port_flush,
  input  logic [PORT_COUNT-1:0]            slot_release,
  input  logic                             req_valid,
  output logic                             req_ready,
  output logic                             grant_valid,
  input  logic                             grant_ready,
  output logic [ADDR_WIDTH-1:0]            grant_port,
  output logic [PORT_COUNT*SLOT_WIDTH-1:0] free_counts,
  output logic                             release_err,
  output logic [31:0]                      alloc_count
);

  localparam logic [SLOT_WIDTH-1:0] MaxCount = SLOT_WIDTH'(MAX_SLOTS);
  localparam logic [SLOT_WIDTH-1:0] OneSlot  = SLOT_WIDTH'(1);

  logic [SLOT_WIDTH-1:0] cnt_q [PORT_COUNT];
  logic [SLOT_WIDTH-1:0] cnt_d [PORT_COUNT];

  logic                  grant_valid_q, grant_valid_d;
  logic [ADDR_WIDTH-1:0] grant_port_q, grant_port_d;
  logic                  release_err_q, release_err_d;
  logic [31:0]           alloc_count_q, alloc_count_d;

  logic [PORT_COUNT*SLOT_WIDTH-1:0] masked_vals;
  logic [SLOT_WIDTH-1:0]            max_val;
  logic [ADDR_WIDTH-1:0]            max_ptr;
  logic                             accept;
  logic                             err_set;

  always_comb begin
    masked_vals = '0;
    free_counts = '0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      masked_vals[i*SLOT_WIDTH +: SLOT_WIDTH] = port_enable[i] ? cnt_q[i] : '0;
      free_counts[i*SLOT_WIDTH +: SLOT_WIDTH] = cnt_q[i];
    end
  end

  max_finder_tree #(
    .NUM_VALUES(PORT_COUNT),
    .VAL_WIDTH (SLOT_WIDTH),
    .IDX_WIDTH (ADDR_WIDTH)
  ) u_max_finder (
    .values_i (masked_vals),
    .max_val_o(max_val),
    .max_ptr_o(max_ptr)
  );

  // A zero maximum means no enabled port has a free slot, which also rules out underflow.
  assign req_ready = !rst && (!grant_valid_q || grant_ready) && (max_val != '0);
  assign accept    = req_valid && req_ready;

  always_comb begin
    err_set = 1'b0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (port_flush[i]) begin
        cnt_d[i] = MaxCount;
      end else if (accept && (max_ptr == ADDR_WIDTH'(i))) begin
        // A same-cycle release cancels the decrement.
        if (!slot_release[i]) begin
          cnt_d[i] = cnt_q[i] - OneSlot;
        end
      end else if (slot_release[i]) begin
        if (cnt_q[i] == MaxCount) begin
          err_set = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + OneSlot;
        end
      end
    end
  end

  always_comb begin
    grant_valid_d = grant_valid_q;
    grant_port_d  = grant_port_q;
    alloc_count_d = alloc_count_q;
    release_err_d = release_err_q | err_set;
    if (accept) begin
      grant_valid_d = 1'b1;
      grant_port_d  = max_ptr;
      alloc_count_d = alloc_count_q + 32'd1;
    end else if (grant_valid_q && grant_ready) begin
      grant_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PORT_COUNT; i++) begin
        cnt_q[i] <= MaxCount;
      end
      grant_valid_q <= 1'b0;
      grant_port_q  <= '0;
      release_err_q <= 1'b0;
      alloc_count_q <= '0;
    end else begin
      for (int i = 0; i < PORT_COUNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      grant_valid_q <= grant_valid_d;
      grant_port_q  <= grant_port_d;
      release_err_q <= release_err_d;
      alloc_count_q <= alloc_count_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_port  = grant_port_q;
  assign release_err = release_err_q;
  assign alloc_count = alloc_count_q;

endmodule

// File: tb/tb_slot_credit_allocator.sv
// Directed bench for slot_credit_allocator: inputs change on the falling edge, outputs are
// checked on the falling edge (registered) or 1 time unit after it (combinational req_ready).

module tb_slot_credit_allocator;

  localparam int P = 16;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [P-1:0]  port_enable, port_flush, slot_release;
  logic          req_valid, req_ready, grant_valid, grant_ready;
  logic [3:0]    grant_port;
  logic [P*W-1:0] free_counts;
  logic          release_err;
  logic [31:0]   alloc_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  slot_credit_allocator dut (
    .clk         (clk),
    .rst         (rst),
    .port_enable (port_enable),
    .port_flush  (port_flush),
    .slot_release(slot_release),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .grant_valid (grant_valid),
    .grant_ready (grant_ready),
    .grant_port  (grant_port),
    .free_counts (free_counts),
    .release_err (release_err),
    .alloc_count (alloc_count)
  );

  function automatic logic [W-1:0] cnt(input int p);
    return free_counts[p*W +: W];
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; grant_ready = 1'b1;
    port_enable = '0; port_flush = '0; slot_release = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called on a falling edge; issues n back-to-back grants on the masked ports.
  task automatic do_grants(input logic [P-1:0] mask, input int n);
    port_enable = mask; grant_ready = 1'b1; req_valid = 1'b1;
    repeat (n) @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; grant_ready = 1'b1;
    port_enable = '1; port_flush = '0; slot_release = '0;
    #12;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0 || grant_port !== 4'd0) begin
      failures++; $display("FAIL reset_grant got=%b/%0d exp=0/0", grant_valid, grant_port);
    end
    checks++;
    if (release_err !== 1'b0 || alloc_count !== 32'd0) begin
      failures++; $display("FAIL reset_err_count got=%b/%0d exp=0/0", release_err, alloc_count);
    end
    for (int i = 0; i < P; i++) begin
      checks++;
      if (cnt(i) !== 8'd16) begin
        failures++; $display("FAIL reset_cnt%0d got=%0d exp=16", i, cnt(i));
      end
    end
  endtask

  task automatic test_sequential();
    port_enable = '1; grant_ready = 1'b1; req_valid = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL seq_ready got=%b exp=1", req_ready);
    end
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      checks++;
      if (grant_valid !== 1'b1 || grant_port !== 4'(g)) begin
        failures++; $display("FAIL seq_grant%0d got=%b/%0d exp=1/%0d", g, grant_valid, grant_port, g);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0) begin
      failures++; $display("FAIL seq_drop got=%b exp=0", grant_valid);
    end
    checks++;
    if (cnt(0) !== 8'd15 || cnt(1) !== 8'd15 || cnt(2) !== 8'd15 || cnt(3) !== 8'd16) begin
      failures++;
      $display("FAIL seq_counts got=%0d,%0d,%0d,%0d exp=15,15,15,16", cnt(0), cnt(1), cnt(2), cnt(3));
    end
    checks++;
    if (alloc_count !== 32'd3) begin
      failures++; $display("FAIL seq_alloc got=%0d exp=3", alloc_count);
    end
  endtask

  task automatic test_tie_priority();
    apply_reset();
    do_grants(16'h0001, 14);
    do_grants(16'h0002, 11);
    do_grants(16'h0004, 11);
    port_enable = 16'h0007; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (grant_valid !== 1'b1 || grant_port !== 4'd1) begin
      failures++; $display("FAIL tie_grant got=%b/%0d exp=1/1", grant_valid, grant_port);
    end
    checks++;
    if (cnt(0) !== 8'd2 || cnt(1) !== 8'd4 || cnt(2) !== 8'd5) begin
      failures++; $display("FAIL tie_counts got=%0d,%0d,%0d exp=2,4,5", cnt(0), cnt(1), cnt(2));
    end
    checks++;
    if (alloc_count !== 32'd37) begin
      failures++; $display("FAIL tie_alloc got=%0d exp=37", alloc_count);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    port_enable = '1; grant_ready = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (req_ready !== 1'b0 || grant_valid !== 1'b1 || grant_port !== 4'd3 || cnt(3) !== 8'd15
          || alloc_count !== 32'd38) begin
        failures++;
        $display("FAIL bp_hold%0d got rdy=%b v=%b p=%0d c3=%0d n=%0d exp 0,1,3,15,38",
                 k, req_ready, grant_valid, grant_port, cnt(3), alloc_count);
      end
      @(negedge clk);
    end
    grant_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release_ready got=%b exp=1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (grant_valid !== 1'b1 || grant_port !== 4'd4 || alloc_count !== 32'd39) begin
      failures++;
      $display("FAIL bp_b2b got=%b/%0d/%0d exp=1/4/39", grant_valid, grant_port, alloc_count);
    end
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0) begin
      failures++; $display("FAIL bp_drop got=%b exp=0", grant_valid);
    end
  endtask

  task automatic test_drain();
    apply_reset();
    do_grants(16'h0008, 16);
    req_valid = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0 || cnt(3) !== 8'd0) begin
      failures++; $display("FAIL drain_empty got=%b/%0d exp=0/0", req_ready, cnt(3));
    end
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0) begin
      failures++; $display("FAIL drain_no_grant got=%b exp=0", grant_valid);
    end
    slot_release = 16'h0008;
    @(negedge clk);
    slot_release = '0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || cnt(3) !== 8'd1) begin
      failures++; $display("FAIL drain_refill got=%b/%0d exp=1/1", req_ready, cnt(3));
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (grant_valid !== 1'b1 || grant_port !== 4'd3 || cnt(3) !== 8'd0) begin
      failures++;
      $display("FAIL drain_regrant got=%b/%0d/%0d exp=1/3/0", grant_valid, grant_port, cnt(3));
    end
    @(negedge clk);
    port_enable = 16'h0000;
    #1;
    checks++;
    if (req_ready !== 1'b0 || cnt(0) !== 8'd16) begin
      failures++; $display("FAIL all_disabled got=%b/%0d exp=0/16", req_ready, cnt(0));
    end
  endtask

  task automatic test_release_err();
    apply_reset();
    slot_release = 16'h0020;
    @(negedge clk);
    slot_release = '0;
    checks++;
    if (cnt(5) !== 8'd16 || release_err !== 1'b1) begin
      failures++; $display("FAIL relerr_full got=%0d/%b exp=16/1", cnt(5), release_err);
    end
    apply_reset();
    port_enable = 16'h0020; req_valid = 1'b1; slot_release = 16'h0020;
    @(negedge clk);
    req_valid = 1'b0; slot_release = '0;
    checks++;
    if (grant_valid !== 1'b1 || grant_port !== 4'd5 || cnt(5) !== 8'd16 || release_err !== 1'b0) begin
      failures++;
      $display("FAIL relerr_cancel got=%b/%0d/%0d/%b exp=1/5/16/0",
               grant_valid, grant_port, cnt(5), release_err);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    apply_reset();
    do_grants(16'h0040, 4);
    checks++;
    if (cnt(6) !== 8'd12) begin
      failures++; $display("FAIL flush_pre got=%0d exp=12", cnt(6));
    end
    port_flush = 16'h0040;
    @(negedge clk);
    port_flush = '0;
    checks++;
    if (cnt(6) !== 8'd16) begin
      failures++; $display("FAIL flush_restore got=%0d exp=16", cnt(6));
    end
    // Flush wins over a same-cycle grant and release on the same port.
    port_flush = 16'h0040; slot_release = 16'h0040; req_valid = 1'b1;
    @(negedge clk);
    port_flush = '0; slot_release = '0; req_valid = 1'b0;
    checks++;
    if (cnt(6) !== 8'd16 || grant_port !== 4'd6 || release_err !== 1'b0) begin
      failures++;
      $display("FAIL flush_override got=%0d/%0d/%b exp=16/6/0", cnt(6), grant_port, release_err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    port_enable = '1; grant_ready = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b1 || cnt(0) !== 8'd15) begin
      failures++; $display("FAIL mid_pre got=%b/%0d exp=1/15", grant_valid, cnt(0));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (grant_valid !== 1'b0 || cnt(0) !== 8'd16 || alloc_count !== 32'd0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=%b/%0d/%0d/%b exp=0/16/0/0",
               grant_valid, cnt(0), alloc_count, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_tie_priority();
    test_backpressure();
    test_drain();
    test_release_err();
    test_flush();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slot_credit_allocator.md
SLOT_CREDIT_ALLOCATOR -- requirements
Module: slot_credit_allocator

Interface
REQ-001 SHALL have parameter PORT_COUNT, default 16: number of destination cores.
REQ-002 SHALL have parameter SLOT_WIDTH, default 8: width of each per-port free-slot counter.
REQ-003 SHALL have parameter MAX_SLOTS, default 16: per-port slot capacity and counter reset value; MAX_SLOTS < 2**SLOT_WIDTH.
REQ-004 SHALL have parameter ADDR_WIDTH, default $clog2(PORT_COUNT): width of the port index.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 SHALL have ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  async active-high reset
- port_enable  in  PORT_COUNT  per-port allocation enable
- port_flush  in  PORT_COUNT  per-port pulse restoring the counter to MAX_SLOTS
- slot_release  in  PORT_COUNT  per-port pulse returning one slot
- req_valid  in  1  allocation request
- req_ready  out  1  request accepted this cycle when high with req_valid
- grant_valid  out  1  registered grant available
- grant_ready  in  1  grant consumer ready
- grant_port  out  ADDR_WIDTH  granted port index
- free_counts  out  PORT_COUNT*SLOT_WIDTH  current counters, port i at bits [i*SLOT_WIDTH +: SLOT_WIDTH]
- release_err  out  1  sticky: release on a full counter
- alloc_count  out  32  total accepted requests

Function
REQ-007 SHALL hold one SLOT_WIDTH free-slot counter per port.
REQ-008 SHALL instantiate max_finder_tree (PORT_COUNT, SLOT_WIDTH, ADDR_WIDTH) with values = counters, each port forced to 0 when its port_enable bit is low.
REQ-009 Ties SHALL resolve to the lowest index, per max_finder_tree strict greater-than ordering.
REQ-010 SHALL drive req_ready = (!grant_valid || grant_ready) && (finder max_val != 0), combinationally.
REQ-011 On req_valid && req_ready, SHALL load grant_port with the finder max_ptr, set grant_valid, decrement that port's counter by 1, and increment alloc_count; latency request-to-grant is 1 cycle.
REQ-012 SHALL hold grant_valid and grant_port stable until grant_valid && grant_ready; clear grant_valid on that cycle unless a new request is accepted the same cycle.
REQ-013 A grant accepted with a concurrent new acceptance SHALL give back-to-back grants with no bubble.
REQ-014 slot_release[i] SHALL increment counter i by 1.
REQ-015 Release on a counter already at MAX_SLOTS SHALL leave it at MAX_SLOTS and set release_err.
REQ-016 Decrement and release on the same port in the same cycle SHALL leave the counter unchanged; this SHALL not set release_err.
REQ-017 port_flush[i] SHALL set counter i to MAX_SLOTS.
REQ-018 port_flush SHALL override release and decrement on that port in the same cycle.
REQ-019 Counters SHALL never underflow; the max_val != 0 gate guarantees it.
REQ-020 When all enabled counters are 0 or all ports are disabled, req_ready SHALL be 0 and no grant SHALL issue.
REQ-021 Disabling a port SHALL not alter its counter; releases continue to be counted.
REQ-022 alloc_count SHALL wrap modulo 2**32.
REQ-023 free_counts SHALL reflect the registered counters, unmasked.

Reset
REQ-024 On rst assertion, asynchronously:
- every counter = MAX_SLOTS
- grant_valid = 0
- grant_port = 0
- release_err = 0
- alloc_count = 0
REQ-025 A grant pending at reset SHALL be discarded; its slot is restored by the counter reset.
REQ-026 While rst is high, req_ready SHALL be 0.

Verification
REQ-027 After reset, all ports enabled, req_valid held with grant_ready=1 for 3 cycles -> grants to ports 0, 1, 2 on consecutive cycles; free_counts ports 0-2 = 15.
REQ-028 Counters {p0=2, p1=5, p2=5}, others disabled; one request -> grant_port=1, p1 becomes 4.
REQ-029 grant_ready=0 while a grant is pending -> req_ready=0, grant_port stable, counters unchanged until grant_ready=1.
REQ-030 Only port 3 enabled, drained to 0 by 16 grants -> req_ready=0; then slot_release[3] -> req_ready=1 next cycle and the next grant is port 3.
REQ-031 Port 5 full (16) with slot_release[5] -> stays 16, release_err=1; same-cycle grant to port 5 plus slot_release[5] -> counter unchanged, no error.
REQ-032 rst asserted mid-stream with grant_valid=1 -> grant_valid=0 immediately, all counters 16, alloc_count=0.
